// File: rtl/ext_bus_ctl.sv
// ext_bus_ctl: external memory-bus M-cycle sequencer (T1, T2, WAIT*, T3, T4) with registered bus outputs.
module ext_bus_ctl #(
  parameter int         WAIT_MAX   = 15,
  parameter logic [7:0] RD_DEFAULT = 8'hFF
) (
  input  logic        CLK,
  input  logic        SYNC_RES,
  input  logic        req,
  input  logic        wr,
  input  logic [7:0]  adl,
  input  logic [7:0]  adh,
  input  logic [7:0]  DL_in,
  output logic [7:0]  DL_out,
  output logic        done,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        nCS,
  output logic        nRD,
  output logic        nWR,
  input  logic        RDY
);
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_WAIT, S_T3, S_T4} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic tflag_q, tflag_d;
  logic wr_q, acc, nx_wr, act, strobe;
  logic [15:0] a_q;
  logic [7:0] dout_q, dl_q;
  logic d_oe_q, ncs_q, nrd_q, nwr_q, done_q, busy_q, to_q;
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    unique case (state_q)
      S_IDLE: state_d = req ? S_T1 : S_IDLE;
      S_T1:   state_d = S_T2;
      S_T2: begin
        state_d = RDY ? S_T3 : S_WAIT;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (RDY) state_d = S_T3;
        else if (cnt_q == 8'(WAIT_MAX - 1)) begin
          state_d = S_T3;
          tflag_d = 1'b1;
        end
      end
      S_T3:   state_d = S_T4;
      S_T4: begin
        tflag_d = 1'b0;
        state_d = req ? S_T1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Outputs are computed from the state being entered so they are valid throughout that state.
  assign acc    = (state_d == S_T1);
  assign nx_wr  = acc ? wr : wr_q;
  assign act    = state_d inside {S_T1, S_T2, S_WAIT, S_T3};
  assign strobe = state_d inside {S_T2, S_WAIT, S_T3};
  always_ff @(posedge CLK) begin
    if (SYNC_RES) begin
      wr_q   <= 1'b0;
      a_q    <= 16'h0000;
      dout_q <= 8'h00;
      dl_q   <= 8'h00;
      d_oe_q <= 1'b0;
      ncs_q  <= 1'b1;
      nrd_q  <= 1'b1;
      nwr_q  <= 1'b1;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      if (acc) begin
        wr_q <= wr;
        a_q  <= {adh, adl};
        if (wr) dout_q <= DL_in;
      end
      if (state_q == S_T3 && !wr_q) dl_q <= tflag_q ? RD_DEFAULT : D_in;
      d_oe_q <= act && nx_wr;
      ncs_q  <= !act;
      nrd_q  <= !(strobe && !wr_q);
      nwr_q  <= !(strobe && wr_q);
      done_q <= (state_d == S_T4);
      busy_q <= (state_d != S_IDLE);
      to_q   <= (state_d == S_T4) && tflag_q;
    end
  end
  assign A       = a_q;
  assign D_out   = dout_q;
  assign D_oe    = d_oe_q;
  assign DL_out  = dl_q;
  assign nCS     = ncs_q;
  assign nRD     = nrd_q;
  assign nWR     = nwr_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_ext_bus_ctl.sv
// tb_ext_bus_ctl: transaction-table model of ext_bus_ctl checked every cycle, plus literal spot checks.
module tb_ext_bus_ctl;
  localparam int WAIT_MAX = 15;
  logic CLK = 1'b0, SYNC_RES, req, wr, RDY, D_oe, nCS, nRD, nWR, done, busy, timeout;
  logic [7:0] adl, adh, DL_in, DL_out, D_out, D_in;
  logic [15:0] A;
  int nc = 0, nf = 0, cyc = 0, rst_cyc = -1, ntx = 0;
  int st[32], kk[32];
  logic w[32];
  logic [15:0] ad[32];
  logic [7:0] dt[32], di[32];

  ext_bus_ctl #(.WAIT_MAX(WAIT_MAX), .RD_DEFAULT(8'hFF)) dut (
    .CLK(CLK), .SYNC_RES(SYNC_RES), .req(req), .wr(wr), .adl(adl), .adh(adh),
    .DL_in(DL_in), .DL_out(DL_out), .done(done), .busy(busy), .timeout(timeout),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in), .nCS(nCS), .nRD(nRD),
    .nWR(nWR), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (SYNC_RES) rst_cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int nw(input int j);
    return kk[j] < WAIT_MAX ? kk[j] : WAIT_MAX;
  endfunction

  // Each transaction: T1 at start, then T2 plus n waits, T3, T4; RDY is low for the first k strobe cycles.
  always @(negedge CLK) begin
    int c, cur, lw, lr, o, n;
    logic tw, e_to;
    logic [15:0] ea;
    c = cyc; cur = -1; lw = -1; lr = -1;
    for (int j = 0; j < ntx; j++)
      if (st[j] <= c && st[j] > rst_cyc) begin
        cur = j;
        if (w[j]) lw = j;
        else if (st[j] + 3 + nw(j) <= c) lr = j;
      end
    if (cur >= 0) begin
      o = c - st[cur]; n = nw(cur); tw = w[cur]; ea = ad[cur]; e_to = kk[cur] > WAIT_MAX;
    end else begin
      o = 1000; n = 0; tw = 1'b0; ea = 16'h0000; e_to = 1'b0;
    end
    RDY  = !(cur >= 0 && o >= 1 && o <= kk[cur]);
    D_in = cur >= 0 ? di[cur] : 8'h00;
    if (rst_cyc >= 0) begin
      chk("busy", 16'(busy), 16'(o <= 3 + n));
      chk("done", 16'(done), 16'(o == 3 + n));
      chk("timeout", 16'(timeout), 16'(o == 3 + n && e_to));
      chk("nCS", 16'(nCS), 16'(!(o <= 2 + n)));
      chk("nRD", 16'(nRD), 16'(!(!tw && o >= 1 && o <= 2 + n)));
      chk("nWR", 16'(nWR), 16'(!(tw && o >= 1 && o <= 2 + n)));
      chk("D_oe", 16'(D_oe), 16'(tw && o <= 2 + n));
      chk("A", A, ea);
      chk("D_out", 16'(D_out), lw >= 0 ? 16'(dt[lw]) : 16'h0);
      chk("DL_out", 16'(DL_out), lr >= 0 ? (kk[lr] > WAIT_MAX ? 16'hFF : 16'(di[lr])) : 16'h0);
    end
  end

  task automatic issue(input logic w_, input logic [15:0] a, input logic [7:0] d, input logic [7:0] din,
                       input int k, input bit hold);
    req = 1'b1; wr = w_; adh = a[15:8]; adl = a[7:0]; DL_in = d;
    st[ntx] = cyc + 1; kk[ntx] = k; w[ntx] = w_; ad[ntx] = a; dt[ntx] = d; di[ntx] = din;
    ntx++;
    @(negedge CLK);
    if (!hold) req = 1'b0;
  endtask

  // Called at the T1 negedge; waits to T4 and pins its literal outcome, then steps into IDLE.
  task automatic finish_txn(input int waits, input logic to_e, input logic [7:0] dl_e);
    repeat (3 + waits) @(negedge CLK);
    chk("lit_done", 16'(done), 16'h1);
    chk("lit_timeout", 16'(timeout), 16'(to_e));
    chk("lit_DL_out", 16'(DL_out), 16'(dl_e));
    @(negedge CLK);
  endtask

  initial begin
    SYNC_RES = 1'b1; req = 1'b0; wr = 1'b0; adl = 8'h00; adh = 8'h00; DL_in = 8'h00;
    repeat (2) @(negedge CLK);
    SYNC_RES = 1'b0;
    @(negedge CLK);
    chk("lit_rst_nCS", 16'(nCS), 16'h1);
    chk("lit_rst_A", A, 16'h0000);
    issue(1'b0, 16'hC012, 8'h00, 8'h5A, 0, 1'b0);
    chk("lit_T1_A", A, 16'hC012);
    finish_txn(0, 1'b0, 8'h5A);
    issue(1'b1, 16'hFF80, 8'hA5, 8'h00, 0, 1'b0);
    chk("lit_wr_D_out", 16'(D_out), 16'h00A5);
    finish_txn(0, 1'b0, 8'h5A);
    issue(1'b0, 16'h1234, 8'h00, 8'h3C, 3, 1'b0);
    finish_txn(3, 1'b0, 8'h3C);
    issue(1'b0, 16'h2000, 8'h00, 8'h77, 20, 1'b0);
    finish_txn(15, 1'b1, 8'hFF);
    issue(1'b0, 16'h2001, 8'h00, 8'h11, 15, 1'b0);
    finish_txn(15, 1'b0, 8'h11);
    issue(1'b0, 16'h2002, 8'h00, 8'h22, 0, 1'b0);
    finish_txn(0, 1'b0, 8'h22);
    issue(1'b0, 16'h0100, 8'h00, 8'h99, 0, 1'b1);
    repeat (3) @(negedge CLK);
    chk("lit_b2b_done1", 16'(done), 16'h1);
    issue(1'b1, 16'h0101, 8'h42, 8'h00, 0, 1'b0);
    chk("lit_b2b_T1_A", A, 16'h0101);
    finish_txn(0, 1'b0, 8'h99);
    issue(1'b0, 16'h3000, 8'h00, 8'h66, 0, 1'b0);
    @(negedge CLK);
    req = 1'b1; wr = 1'b1; adh = 8'hDE; adl = 8'hAD;
    @(negedge CLK);
    req = 1'b0;
    @(negedge CLK);
    chk("lit_ign_done", 16'(done), 16'h1);
    @(negedge CLK);
    chk("lit_ign_busy", 16'(busy), 16'h0);
    chk("lit_ign_A", A, 16'h3000);
    issue(1'b0, 16'h4000, 8'h00, 8'h55, 10, 1'b0);
    repeat (2) @(negedge CLK);
    SYNC_RES = 1'b1;
    @(negedge CLK);
    SYNC_RES = 1'b0;
    chk("lit_res_nRD", 16'(nRD), 16'h1);
    chk("lit_res_busy", 16'(busy), 16'h0);
    chk("lit_res_done", 16'(done), 16'h0);
    chk("lit_res_DL_out", 16'(DL_out), 16'h00);
    @(negedge CLK);
    issue(1'b0, 16'h4001, 8'h00, 8'h88, 0, 1'b0);
    finish_txn(0, 1'b0, 8'h88);
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
